// File: rtl/pacman_pkg.sv
// Shared maze-game definitions: coordinate width, monster start positions,
// scheduler state encoding and the single-axis step helper.
package pacman_pkg;

   localparam int unsigned COORD_W = 9;

   localparam logic [COORD_W-1:0] M1_X = 9'd8;
   localparam logic [COORD_W-1:0] M1_Y = 9'd8;
   localparam logic [COORD_W-1:0] M2_X = 9'd264;
   localparam logic [COORD_W-1:0] M2_Y = 9'd8;
   localparam logic [COORD_W-1:0] M3_X = 9'd136;
   localparam logic [COORD_W-1:0] M3_Y = 9'd152;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SEL    = 3'd1,
      S_Q1     = 3'd2,
      S_Q2     = 3'd3,
      S_COMMIT = 3'd4,
      S_NEXT   = 3'd5
   } state_e;

   // Returns {ok, coord}: one step toward the target on one axis; ok=0 when
   // the delta is zero or the step would leave [0, lim].
   function automatic logic [COORD_W:0] step_toward(
      input logic        [COORD_W-1:0] pos,
      input logic signed [COORD_W:0]   delta,
      input logic        [COORD_W-1:0] lim,
      input int unsigned               step
   );
      logic [COORD_W+1:0] wide;
      logic [COORD_W+1:0] st;
      st          = (COORD_W+2)'(step);
      wide        = '0;
      step_toward = '0;
      if (delta > 0) begin
         wide = {2'b00, pos} + st;
         if (wide <= {2'b00, lim}) begin
            step_toward = {1'b1, wide[COORD_W-1:0]};
         end
      end else if (delta < 0) begin
         if ({2'b00, pos} >= st) begin
            step_toward = {1'b1, pos - st[COORD_W-1:0]};
         end
      end
   endfunction

endpackage

// File: rtl/monster_step.sv
// Combinational chase step: picks primary/secondary axis toward Pacman and
// produces the two candidate coordinates with their in-range/non-zero flags.
module monster_step
   import pacman_pkg::*;
#(
   parameter int unsigned          STEP  = 1,
   parameter logic [COORD_W-1:0]   X_MAX = 9'd279,
   parameter logic [COORD_W-1:0]   Y_MAX = 9'd303
) (
   input  logic [COORD_W-1:0] m_x,
   input  logic [COORD_W-1:0] m_y,
   input  logic [COORD_W-1:0] p_x,
   input  logic [COORD_W-1:0] p_y,
   output logic               prim_ok_c,
   output logic [COORD_W-1:0] prim_x_c,
   output logic [COORD_W-1:0] prim_y_c,
   output logic               sec_ok_c,
   output logic [COORD_W-1:0] sec_x_c,
   output logic [COORD_W-1:0] sec_y_c,
   output logic               no_delta_c
);

   logic signed [COORD_W:0] dx;
   logic signed [COORD_W:0] dy;
   logic        [COORD_W:0] adx;
   logic        [COORD_W:0] ady;
   logic        [COORD_W:0] xc;
   logic        [COORD_W:0] yc;
   logic                    x_first;

   always_comb begin
      dx      = $signed({1'b0, p_x}) - $signed({1'b0, m_x});
      dy      = $signed({1'b0, p_y}) - $signed({1'b0, m_y});
      adx     = dx[COORD_W] ? (COORD_W+1)'(-dx) : (COORD_W+1)'(dx);
      ady     = dy[COORD_W] ? (COORD_W+1)'(-dy) : (COORD_W+1)'(dy);
      xc      = step_toward(m_x, dx, X_MAX, STEP);
      yc      = step_toward(m_y, dy, Y_MAX, STEP);
      // Ties favour the x axis
      x_first = (adx >= ady);

      prim_ok_c  = x_first ? xc[COORD_W] : yc[COORD_W];
      prim_x_c   = x_first ? xc[COORD_W-1:0] : m_x;
      prim_y_c   = x_first ? m_y : yc[COORD_W-1:0];
      sec_ok_c   = x_first ? yc[COORD_W] : xc[COORD_W];
      sec_x_c    = x_first ? m_x : xc[COORD_W-1:0];
      sec_y_c    = x_first ? yc[COORD_W-1:0] : m_y;
      no_delta_c = (dx == '0) && (dy == '0);
   end

endmodule

// File: rtl/monster_scheduler.sv
// Moves three monsters one step toward Pacman per tick, one at a time,
// checking each candidate square against the shared maze ROM.
module monster_scheduler
   import pacman_pkg::*;
#(
   parameter int unsigned        STEP  = 1,
   parameter logic [COORD_W-1:0] X_MAX = 9'd279,
   parameter logic [COORD_W-1:0] Y_MAX = 9'd303
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               tick,
   input  logic [COORD_W-1:0] p_x,
   input  logic [COORD_W-1:0] p_y,
   output logic               wall_req,
   output logic [COORD_W-1:0] wall_x,
   output logic [COORD_W-1:0] wall_y,
   input  logic               wall_ack,
   input  logic               wall_hit,
   output logic [COORD_W-1:0] m1_x,
   output logic [COORD_W-1:0] m1_y,
   output logic [COORD_W-1:0] m2_x,
   output logic [COORD_W-1:0] m2_y,
   output logic [COORD_W-1:0] m3_x,
   output logic [COORD_W-1:0] m3_y,
   output logic               busy,
   output logic               round_done,
   output logic               caught,
   output logic               overrun
);

   state_e                  state_q, state_d;
   logic [1:0]              idx_q, idx_d;
   logic                    pend_q, pend_d;
   logic [COORD_W-1:0]      tx_q, tx_d;
   logic [COORD_W-1:0]      ty_q, ty_d;
   logic [2:0][COORD_W-1:0] mx_q, mx_d;
   logic [2:0][COORD_W-1:0] my_q, my_d;
   logic                    mv_q, mv_d;
   logic                    wall_req_q, wall_req_d;
   logic [COORD_W-1:0]      wall_x_q, wall_x_d;
   logic [COORD_W-1:0]      wall_y_q, wall_y_d;
   logic                    busy_q, busy_d;
   logic                    round_done_q, round_done_d;
   logic                    caught_q, caught_d;
   logic                    overrun_q, overrun_d;

   logic [COORD_W-1:0]      cur_x_c, cur_y_c;
   logic                    prim_ok_c, sec_ok_c, no_delta_c;
   logic [COORD_W-1:0]      prim_x_c, prim_y_c, sec_x_c, sec_y_c;

   // Position of the monster currently being processed
   always_comb begin
      case (idx_q)
         2'd2:    begin cur_x_c = mx_q[1]; cur_y_c = my_q[1]; end
         2'd3:    begin cur_x_c = mx_q[2]; cur_y_c = my_q[2]; end
         default: begin cur_x_c = mx_q[0]; cur_y_c = my_q[0]; end
      endcase
   end

   monster_step #(
      .STEP  (STEP),
      .X_MAX (X_MAX),
      .Y_MAX (Y_MAX)
   ) u_step (
      .m_x        (cur_x_c),
      .m_y        (cur_y_c),
      .p_x        (tx_q),
      .p_y        (ty_q),
      .prim_ok_c  (prim_ok_c),
      .prim_x_c   (prim_x_c),
      .prim_y_c   (prim_y_c),
      .sec_ok_c   (sec_ok_c),
      .sec_x_c    (sec_x_c),
      .sec_y_c    (sec_y_c),
      .no_delta_c (no_delta_c)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         idx_q        <= 2'd1;
         pend_q       <= 1'b0;
         tx_q         <= '0;
         ty_q         <= '0;
         mx_q         <= {M3_X, M2_X, M1_X};
         my_q         <= {M3_Y, M2_Y, M1_Y};
         mv_q         <= 1'b0;
         wall_req_q   <= 1'b0;
         wall_x_q     <= '0;
         wall_y_q     <= '0;
         busy_q       <= 1'b0;
         round_done_q <= 1'b0;
         caught_q     <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         pend_q       <= pend_d;
         tx_q         <= tx_d;
         ty_q         <= ty_d;
         mx_q         <= mx_d;
         my_q         <= my_d;
         mv_q         <= mv_d;
         wall_req_q   <= wall_req_d;
         wall_x_q     <= wall_x_d;
         wall_y_q     <= wall_y_d;
         busy_q       <= busy_d;
         round_done_q <= round_done_d;
         caught_q     <= caught_d;
         overrun_q    <= overrun_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      pend_d       = pend_q;
      tx_d         = tx_q;
      ty_d         = ty_q;
      mx_d         = mx_q;
      my_d         = my_q;
      mv_d         = mv_q;
      wall_req_d   = wall_req_q;
      wall_x_d     = wall_x_q;
      wall_y_d     = wall_y_q;
      round_done_d = 1'b0;
      caught_d     = caught_q;
      overrun_d    = overrun_q;

      // Ticks during a round queue one deep; a further one is lost
      if (tick && (state_q != S_IDLE)) begin
         if (pend_q) overrun_d = 1'b1;
         else        pend_d    = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (tick || pend_q) begin
               tx_d    = p_x;
               ty_d    = p_y;
               pend_d  = pend_q && tick;
               idx_d   = 2'd1;
               state_d = S_SEL;
            end
         end
         S_SEL: begin
            mv_d    = 1'b0;
            state_d = no_delta_c ? S_COMMIT : S_Q1;
         end
         // First Q cycle raises the request; later cycles wait for the ack
         S_Q1: begin
            if (!wall_req_q) begin
               if (prim_ok_c) begin
                  wall_req_d = 1'b1;
                  wall_x_d   = prim_x_c;
                  wall_y_d   = prim_y_c;
               end else begin
                  state_d = S_Q2;
               end
            end else if (wall_ack) begin
               wall_req_d = 1'b0;
               if (!wall_hit) begin
                  mv_d    = 1'b1;
                  state_d = S_COMMIT;
               end else begin
                  state_d = S_Q2;
               end
            end
         end
         S_Q2: begin
            if (!wall_req_q) begin
               if (sec_ok_c) begin
                  wall_req_d = 1'b1;
                  wall_x_d   = sec_x_c;
                  wall_y_d   = sec_y_c;
               end else begin
                  state_d = S_COMMIT;
               end
            end else if (wall_ack) begin
               wall_req_d = 1'b0;
               mv_d       = !wall_hit;
               state_d    = S_COMMIT;
            end
         end
         // The accepted candidate is still held on wall_x/wall_y
         S_COMMIT: begin
            if (mv_q) begin
               case (idx_q)
                  2'd1:    begin mx_d[0] = wall_x_q; my_d[0] = wall_y_q; end
                  2'd2:    begin mx_d[1] = wall_x_q; my_d[1] = wall_y_q; end
                  2'd3:    begin mx_d[2] = wall_x_q; my_d[2] = wall_y_q; end
                  default: ;
               endcase
            end
            state_d = S_NEXT;
         end
         S_NEXT: begin
            if (idx_q != 2'd3) begin
               idx_d   = idx_q + 2'd1;
               state_d = S_SEL;
            end else begin
               round_done_d = 1'b1;
               caught_d     = 1'b0;
               for (int k = 0; k < 3; k++) begin
                  if ((mx_q[k] == tx_q) && (my_q[k] == ty_q)) caught_d = 1'b1;
               end
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   assign wall_req   = wall_req_q;
   assign wall_x     = wall_x_q;
   assign wall_y     = wall_y_q;
   assign m1_x       = mx_q[0];
   assign m1_y       = my_q[0];
   assign m2_x       = mx_q[1];
   assign m2_y       = my_q[1];
   assign m3_x       = mx_q[2];
   assign m3_y       = my_q[2];
   assign busy       = busy_q;
   assign round_done = round_done_q;
   assign caught     = caught_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_monster_scheduler.sv
// Bench for monster_scheduler: directed and random move rounds checked
// against a coordinate-level chase model with a behavioural maze ROM.
module tb_monster_scheduler;

   localparam int TB_STEP  = 1;
   localparam int TB_X_MAX = 279;
   localparam int TB_Y_MAX = 303;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick = 1'b0;
   logic [8:0] p_x = '0, p_y = '0;
   logic       wall_req;
   logic [8:0] wall_x, wall_y;
   logic       wall_ack, wall_hit;
   logic [8:0] m1_x, m1_y, m2_x, m2_y, m3_x, m3_y;
   logic       busy, round_done, caught, overrun;

   int total = 0;
   int bad   = 0;

   logic [17:0] walls[$];
   logic [17:0] req_log[$];
   logic [17:0] exp_req[$];
   int exp_x[3];
   int exp_y[3];
   int rom_delay = 0;
   bit rom_on = 1'b1;
   bit force_ack = 1'b0;
   bit unstable = 1'b0;
   bit req_when_idle = 1'b0;

   monster_scheduler #(
      .STEP  (TB_STEP),
      .X_MAX (9'(TB_X_MAX)),
      .Y_MAX (9'(TB_Y_MAX))
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick),
      .p_x        (p_x),
      .p_y        (p_y),
      .wall_req   (wall_req),
      .wall_x     (wall_x),
      .wall_y     (wall_y),
      .wall_ack   (wall_ack),
      .wall_hit   (wall_hit),
      .m1_x       (m1_x),
      .m1_y       (m1_y),
      .m2_x       (m2_x),
      .m2_y       (m2_y),
      .m3_x       (m3_x),
      .m3_y       (m3_y),
      .busy       (busy),
      .round_done (round_done),
      .caught     (caught),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic bit is_wall(input int x, input int y);
      foreach (walls[i]) if (walls[i] == {9'(x), 9'(y)}) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   // One monster's move: try the longer axis first, then the other one
   function automatic void model_move(input int k, input int px, input int py);
      int dx, dy, d, pos, lim, c, cx, cy;
      bit xfirst, use_x;
      dx = px - exp_x[k];
      dy = py - exp_y[k];
      if (dx == 0 && dy == 0) return;
      xfirst = iabs(dx) >= iabs(dy);
      for (int pass = 0; pass < 2; pass++) begin
         use_x = (pass == 0) ? xfirst : !xfirst;
         d     = use_x ? dx : dy;
         pos   = use_x ? exp_x[k] : exp_y[k];
         lim   = use_x ? TB_X_MAX : TB_Y_MAX;
         if (d == 0) continue;
         c = pos + ((d > 0) ? TB_STEP : -TB_STEP);
         if (c < 0 || c > lim) continue;
         cx = use_x ? c : exp_x[k];
         cy = use_x ? exp_y[k] : c;
         exp_req.push_back({9'(cx), 9'(cy)});
         if (!is_wall(cx, cy)) begin
            exp_x[k] = cx;
            exp_y[k] = cy;
            return;
         end
      end
   endfunction

   function automatic void model_reset();
      exp_x[0] = 8;   exp_y[0] = 8;
      exp_x[1] = 264; exp_y[1] = 8;
      exp_x[2] = 136; exp_y[2] = 152;
   endfunction

   function automatic bit model_caught(input int px, input int py);
      for (int k = 0; k < 3; k++) if (exp_x[k] == px && exp_y[k] == py) return 1'b1;
      return 1'b0;
   endfunction

   // Maze ROM: answers after rom_delay waiting cycles, watches address stability
   initial begin
      int          waited;
      logic [17:0] held;
      bit          holding;
      waited = 0; held = '0; holding = 1'b0;
      wall_ack = 1'b0; wall_hit = 1'b0;
      forever begin
         @(posedge clk); #1;
         wall_ack = 1'b0;
         wall_hit = 1'b0;
         if (wall_req && !busy) req_when_idle = 1'b1;
         if (wall_req) begin
            if (holding && held !== {wall_x, wall_y}) unstable = 1'b1;
            if (!holding) begin
               holding = 1'b1;
               held    = {wall_x, wall_y};
               waited  = 0;
            end
         end else begin
            holding = 1'b0;
         end
         if (force_ack) begin
            wall_ack = 1'b1;
         end else if (wall_req && rom_on) begin
            if (waited >= rom_delay) begin
               wall_ack = 1'b1;
               wall_hit = is_wall(int'(wall_x), int'(wall_y));
               req_log.push_back({wall_x, wall_y});
               holding  = 1'b0;
            end else begin
               waited++;
            end
         end
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      tick  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic check_pos(input string tag);
      chk({tag, ".m1_x"}, 32'(m1_x), exp_x[0]);
      chk({tag, ".m1_y"}, 32'(m1_y), exp_y[0]);
      chk({tag, ".m2_x"}, 32'(m2_x), exp_x[1]);
      chk({tag, ".m2_y"}, 32'(m2_y), exp_y[1]);
      chk({tag, ".m3_x"}, 32'(m3_x), exp_x[2]);
      chk({tag, ".m3_y"}, 32'(m3_y), exp_y[2]);
   endtask

   task automatic do_round(input int px, input int py, input int dly, input string tag);
      int cyc;
      exp_req.delete();
      req_log.delete();
      for (int k = 0; k < 3; k++) model_move(k, px, py);
      rom_delay = dly;
      p_x  = 9'(px);
      p_y  = 9'(py);
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
      chk({tag, ".busy_rise"}, 32'(busy), 1);
      cyc = 0;
      while (!round_done && cyc < 400) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk({tag, ".round_done"}, 32'(round_done), 1);
      @(posedge clk); #1;
      chk({tag, ".done_pulse"}, 32'(round_done), 0);
      chk({tag, ".busy_fall"}, 32'(busy), 0);
      check_pos(tag);
      chk({tag, ".caught"}, 32'(caught), 32'(model_caught(px, py)));
      chk({tag, ".nreq"}, req_log.size(), exp_req.size());
      for (int i = 0; i < req_log.size() && i < exp_req.size(); i++)
         chk({tag, ".req"}, 32'(req_log[i]), 32'(exp_req[i]));
   endtask

   initial begin
      int cyc, pulses, px, py, dly, k;
      model_reset();
      do_reset();

      // Reset state
      check_pos("reset");
      chk("reset.busy", 32'(busy), 0);
      chk("reset.wall_req", 32'(wall_req), 0);
      chk("reset.wall_x", 32'(wall_x), 0);
      chk("reset.wall_y", 32'(wall_y), 0);
      chk("reset.round_done", 32'(round_done), 0);
      chk("reset.caught", 32'(caught), 0);
      chk("reset.overrun", 32'(overrun), 0);

      // Open maze, Pacman at (20,8)
      do_round(20, 8, 0, "basic");
      chk("basic.m1_x_const", 32'(m1_x), 9);
      chk("basic.m2_x_const", 32'(m2_x), 263);
      chk("basic.m3_y_const", 32'(m3_y), 151);

      // Monster 1 lands on Pacman
      do_reset();
      do_round(9, 8, 1, "catch");
      chk("catch.const", 32'(caught), 1);

      // Primary candidate blocked, secondary taken
      do_reset();
      walls.delete();
      walls.push_back({9'd9, 9'd8});
      do_round(20, 20, 2, "wall1");
      chk("wall1.m1_x_const", 32'(m1_x), 8);
      chk("wall1.m1_y_const", 32'(m1_y), 9);

      // Both candidates blocked
      do_reset();
      walls.push_back({9'd8, 9'd9});
      do_round(20, 20, 1, "wall2");
      chk("wall2.m1_x_const", 32'(m1_x), 8);
      chk("wall2.m1_y_const", 32'(m1_y), 8);

      // Walk monster 2 to the right edge, then push past it with slow acks
      do_reset();
      walls.delete();
      for (int r = 0; r < 15; r++) do_round(400, 8, 0, "walk");
      chk("walk.m2_x_const", 32'(m2_x), 279);
      unstable = 1'b0;
      do_round(400, 8, 5, "edge");
      chk("edge.m2_x_const", 32'(m2_x), 279);
      chk("edge.stable", 32'(unstable), 0);

      // Random rounds with random walls around the monsters
      do_reset();
      for (int r = 0; r < 30; r++) begin
         walls.delete();
         for (int m = 0; m < 3; m++) begin
            if ($urandom_range(0, 99) < 30) walls.push_back({9'(exp_x[m] + 1), 9'(exp_y[m])});
            if ($urandom_range(0, 99) < 30) walls.push_back({9'(exp_x[m] - 1), 9'(exp_y[m])});
            if ($urandom_range(0, 99) < 30) walls.push_back({9'(exp_x[m]), 9'(exp_y[m] + 1)});
            if ($urandom_range(0, 99) < 30) walls.push_back({9'(exp_x[m]), 9'(exp_y[m] - 1)});
         end
         if ($urandom_range(0, 5) == 0) begin
            k  = int'($urandom_range(0, 2));
            px = exp_x[k];
            py = exp_y[k];
         end else begin
            px = int'($urandom_range(0, 320));
            py = int'($urandom_range(0, 320));
         end
         dly = int'($urandom_range(0, 3));
         do_round(px, py, dly, "rand");
      end
      walls.delete();

      // Three ticks during one round: one queued, one dropped
      do_reset();
      rom_delay = 2;
      exp_req.delete();
      for (int k2 = 0; k2 < 3; k2++) model_move(k2, 50, 60);
      for (int k2 = 0; k2 < 3; k2++) model_move(k2, 50, 60);
      p_x = 9'd50;
      p_y = 9'd60;
      pulses = 0;
      for (int t = 0; t < 3; t++) begin
         tick = 1'b1;
         @(posedge clk); #1;
         tick = 1'b0;
         if (round_done) pulses++;
         repeat (3) begin
            @(posedge clk); #1;
            if (round_done) pulses++;
         end
      end
      chk("ovr.overrun_set", 32'(overrun), 1);
      for (int c = 0; c < 300; c++) begin
         @(posedge clk); #1;
         if (round_done) pulses++;
      end
      chk("ovr.rounds", pulses, 2);
      chk("ovr.busy", 32'(busy), 0);
      check_pos("ovr");
      chk("ovr.overrun_sticky", 32'(overrun), 1);

      // Reset in the middle of a handshake, then a stray ack
      rom_on = 1'b0;
      p_x  = 9'd20;
      p_y  = 9'd8;
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
      cyc = 0;
      while (!wall_req && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("mid.req_seen", 32'(wall_req), 1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      chk("mid.wall_req", 32'(wall_req), 0);
      chk("mid.busy", 32'(busy), 0);
      chk("mid.overrun", 32'(overrun), 0);
      check_pos("mid");
      force_ack = 1'b1;
      @(posedge clk); #1;
      force_ack = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("late_ack.wall_req", 32'(wall_req), 0);
      chk("late_ack.busy", 32'(busy), 0);
      check_pos("late_ack");
      rom_on = 1'b1;

      // Normal operation after the disturbed reset
      do_round(20, 8, 1, "recover");
      chk("global.req_only_busy", 32'(req_when_idle), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
